maxnet_neuron_mac: RTL and testbench
====================================

// Module: maxnet_neuron_mac
// PURPOSE
//  Upstream stage of the Maxnet activation function; one instance per neuron.
//  Accepts N_TERMS (activation, weight) pairs serially and accumulates their signed Q-format products.
//  Then presents the weighted sum plus a sign-derived select, driving the activation mux directly.
//  select_out=1 means the sum is negative, so the activation stage outputs zero.
// PARAMETERS
//  DATA_W   32  width of activations, weights, sum_out (signed two's complement)
//  FRAC_W   16  fractional bits (Q16.16 at defaults)
//  N_TERMS  4   pairs per sum (self term + N_TERMS-1 lateral terms)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       begin a new sum (pulse)
//  in_valid   in   1       x_in/w_in valid
//  in_ready   out  1       block accepts a pair this cycle
//  x_in       in   DATA_W  activation term
//  w_in       in   DATA_W  weight term
//  out_valid  out  1       sum_out/select_out valid
//  out_ready  in   1       downstream consumes result
//  sum_out    out  DATA_W  weighted sum, feeds activation data input
//  select_out out  1       sum_out[DATA_W-1], feeds activation select
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, acc=0, cnt=0; in_ready=0, out_valid=0, sum_out=0, select_out=0.
//  - States:
//    - IDLE: start=1 -> ACCUM, acc<=0, cnt<=0.
//    - ACCUM: in_ready=1; a beat is accepted when in_valid&in_ready.
//      - Each beat: acc<=acc+((x_in*w_in)>>>FRAC_W), cnt<=cnt+1.
//      - Beat with cnt==N_TERMS-1 -> HOLD.
//    - HOLD: in_ready=0, out_valid=1; out_valid&out_ready -> IDLE.
//  - Arithmetic:
//    - Full signed 2*DATA_W product; arithmetic right shift by FRAC_W (truncation toward -inf).
//    - acc width ACC_W=2*DATA_W-FRAC_W; acc wraps at ACC_W.
//  - Latency: out_valid and sum_out are registered, asserted the cycle after the last beat is accepted.
//  - sum_out/select_out stable throughout HOLD.
//    - Registered outputs update only on the HOLD entry edge.
//    - They hold their last value in IDLE/ACCUM, with out_valid=0.
//  - Edge cases:
//    - start in ACCUM: restart; acc<=0, cnt<=0; any beat offered that cycle is dropped.
//    - start in HOLD: ignored.
//    - start and out_ready in the same HOLD cycle: return to IDLE; start ignored.
//    - in_valid outside ACCUM: ignored (in_ready=0).
//    - reset mid-ACCUM/HOLD: partial sum discarded; all outputs return to reset values immediately.
//  - cnt width: $clog2(N_TERMS+1).
// CONFIGURATION
//  MAXNET_MAC_SATURATE_EN
//    - defined: ACC_W->DATA_W conversion clamps.
//      - above max -> {0,{DATA_W-1{1}}}; below min -> {1,{DATA_W-1{0}}}.
//    - undefined: sum_out = acc[DATA_W-1:0] (wrap), select_out = that bit DATA_W-1.
// TESTING
//  1. Positive sum: x=[2.0,1.0,1.0,0.5], w=[1.0,-0.25,-0.25,-0.25].
//     -> sum_out=0x00016000, select_out=0, 1 cycle after last beat.
//  2. Negative sum: x=[0.5,1.0,1.0,1.0], same w.
//     -> sum_out=0xFFFFC000, select_out=1.
//  3. Overflow: x=0x7FFF0000 x4, w=1.0 x4.
//     -> SATURATE_EN: 0x7FFFFFFF, select_out=0; without: 0xFFFC0000, select_out=1.
//  4. Backpressure: out_ready=0 for 3 cycles in HOLD.
//     -> out_valid=1, sum_out stable, in_ready=0; IDLE the cycle after out_ready=1.
//  5. Restart/reset: start again after 2 beats of test 1, then run test 2 -> 0xFFFFC000.
//     Separately, rst_n=0 after 2 beats -> outputs 0, state IDLE; a fresh test 1 gives 0x00016000.
//  6. Gaps: in_valid toggled every other cycle during test 1 -> same result; only valid beats counted.

Source files
------------

// File: rtl/maxnet_neuron_mac.sv
// maxnet_neuron_mac
// Serial multiply-accumulate front end for one Maxnet neuron. Takes N_TERMS
// (activation, weight) pairs, sums their signed fixed-point products and
// presents the result with a "sum is negative" select for the activation mux.
// Optional build macro: MAXNET_MAC_SATURATE_EN
//   defined   -> the wide accumulator is clamped into DATA_W bits
//   undefined -> the low DATA_W bits of the accumulator are presented (wrap)
module maxnet_neuron_mac #(
    parameter int DATA_W  = 32,
    parameter int FRAC_W  = 16,
    parameter int N_TERMS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [DATA_W-1:0] sum_out,
    output logic                     select_out
);

    localparam int ACC_W = 2*DATA_W - FRAC_W;
    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_next;
    logic        [CNT_W-1:0]   cnt;
    logic        [CNT_W-1:0]   cnt_next;
    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]   product_term;
    logic        [DATA_W-1:0]  sum_conv;
    logic                      hold_entry;

    // Full-precision signed product, rescaled back to the Q format by an
    // arithmetic shift (rounds toward minus infinity), then cut to ACC_W.
    assign product      = x_in * w_in;
    assign product_term = ACC_W'(product >>> FRAC_W);

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    // Next-state, accumulator and beat-counter logic; a start while
    // accumulating restarts the sum and drops whatever beat is offered.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                    acc_next   = '0;
                    cnt_next   = '0;
                end
            end
            ACCUM: begin
                if (start) begin
                    acc_next = '0;
                    cnt_next = '0;
                end else if (in_valid) begin
                    acc_next = acc + product_term;
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign hold_entry = (state == ACCUM) && (state_next == HOLD);

`ifdef MAXNET_MAC_SATURATE_EN
    logic [ACC_W-DATA_W:0] acc_upper;
    logic                  acc_fits;

    assign acc_upper = acc_next[ACC_W-1:DATA_W-1];
    assign acc_fits  = (&acc_upper) | ~(|acc_upper);

    // Clamp the wide sum into DATA_W bits when it is out of range.
    always_comb begin
        sum_conv = acc_next[DATA_W-1:0];
        if (!acc_fits) begin
            sum_conv = acc_next[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                         : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    // Present the low DATA_W bits of the wide sum; overflow wraps.
    always_comb begin
        sum_conv = acc_next[DATA_W-1:0];
    end
`endif

    // State, accumulator and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
        end
    end

    // Result registers load only when the final beat moves us into HOLD,
    // so they stay stable through HOLD and keep their value afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_out    <= '0;
            select_out <= 1'b0;
        end else if (hold_entry) begin
            sum_out    <= sum_conv;
            select_out <= sum_conv[DATA_W-1];
        end
    end

endmodule

// File: tb/tb_maxnet_neuron_mac.sv
// tb_maxnet_neuron_mac
// Self-checking bench for maxnet_neuron_mac: directed cases plus randomized
// transactions compared against an arithmetic reference model.
// Honours MAXNET_MAC_SATURATE_EN the same way as the design.
module tb_maxnet_neuron_mac;

    localparam int DATA_W  = 32;
    localparam int FRAC_W  = 16;
    localparam int N_TERMS = 4;

    typedef logic [DATA_W-1:0] word_t;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  start;
    logic  in_valid;
    logic  in_ready;
    word_t x_in;
    word_t w_in;
    logic  out_valid;
    logic  out_ready;
    word_t sum_out;
    logic  select_out;

    int checks = 0;
    int errors = 0;

    word_t t1_x [N_TERMS] = '{32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000};
    word_t t2_x [N_TERMS] = '{32'h0000_8000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    word_t t12_w[N_TERMS] = '{32'h0001_0000, 32'hFFFF_C000, 32'hFFFF_C000, 32'hFFFF_C000};
    word_t t3_x [N_TERMS] = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000};
    word_t t3_w [N_TERMS] = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};

`ifdef MAXNET_MAC_SATURATE_EN
    localparam word_t OVF_SUM = 32'h7FFF_FFFF;
`else
    localparam word_t OVF_SUM = 32'hFFFC_0000;
`endif

    // Free-running clock.
    always #5 clk = ~clk;

    maxnet_neuron_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .N_TERMS(N_TERMS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .w_in      (w_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .select_out(select_out)
    );

    // Reference: sum of floor(x*w / 2^FRAC_W) over all terms, wrapped to a
    // (2*DATA_W-FRAC_W)-bit signed accumulator, then converted to DATA_W.
    function automatic word_t model_sum(input word_t xs[N_TERMS], input word_t ws[N_TERMS]);
        longint scale = longint'(1) << FRAC_W;
        longint total = 0;
        longint p;
        longint q;
        for (int i = 0; i < N_TERMS; i++) begin
            p = longint'($signed(xs[i])) * longint'($signed(ws[i]));
            q = p / scale;
            if (p < 0 && (p % scale) != 0) q = q - 1;
            total = total + q;
        end
        total = (total <<< (64 - (2*DATA_W - FRAC_W))) >>> (64 - (2*DATA_W - FRAC_W));
`ifdef MAXNET_MAC_SATURATE_EN
        if (total > longint'(32'h7FFF_FFFF)) return 32'h7FFF_FFFF;
        if (total < -longint'(32'h8000_0000)) return 32'h8000_0000;
`endif
        return word_t'(total);
    endfunction

    // Pulse start for one cycle; returns on the negedge after it was seen.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer beats [first, first+count); gap_mode 0 = back to back,
    // 1 = idle cycle before every beat, 2 = random idle cycles.
    task automatic feed(input word_t xs[N_TERMS], input word_t ws[N_TERMS],
                        input int first, input int count, input int gap_mode);
        for (int i = first; i < first + count; i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                x_in     = $urandom;
                w_in     = $urandom;
                @(negedge clk);
            end
            in_valid = 1'b1;
            x_in     = xs[i];
            w_in     = ws[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        w_in      = '0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (sum_out !== '0)       begin errors++; $display("[TB] FAIL reset_sum got=%h exp=0", sum_out); end
        checks++; if (select_out !== 1'b0)  begin errors++; $display("[TB] FAIL reset_select got=%b exp=0", select_out); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("[TB] FAIL idle_in_ready got=%b exp=0", in_ready); end
    endtask

    // Directed cases: positive, negative and overflowing sums.
    task automatic test_directed();
        pulse_start();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL accum_in_ready got=%b exp=1", in_ready); end
        feed(t1_x, t12_w, 0, N_TERMS - 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL early_valid got=%b exp=0", out_valid); end
        feed(t1_x, t12_w, N_TERMS - 1, 1, 0);
        checks++; if (out_valid !== 1'b1)       begin errors++; $display("[TB] FAIL pos_valid got=%b exp=1", out_valid); end
        checks++; if (sum_out !== 32'h0001_6000) begin errors++; $display("[TB] FAIL pos_sum got=%h exp=00016000", sum_out); end
        checks++; if (select_out !== 1'b0)      begin errors++; $display("[TB] FAIL pos_select got=%b exp=0", select_out); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0)       begin errors++; $display("[TB] FAIL pos_release got=%b exp=0", out_valid); end
        checks++; if (sum_out !== 32'h0001_6000) begin errors++; $display("[TB] FAIL idle_hold_sum got=%h exp=00016000", sum_out); end

        pulse_start();
        feed(t2_x, t12_w, 0, N_TERMS, 0);
        checks++; if (out_valid !== 1'b1)       begin errors++; $display("[TB] FAIL neg_valid got=%b exp=1", out_valid); end
        checks++; if (sum_out !== 32'hFFFF_C000) begin errors++; $display("[TB] FAIL neg_sum got=%h exp=ffffc000", sum_out); end
        checks++; if (select_out !== 1'b1)      begin errors++; $display("[TB] FAIL neg_select got=%b exp=1", select_out); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

        pulse_start();
        feed(t3_x, t3_w, 0, N_TERMS, 0);
        checks++; if (sum_out !== OVF_SUM)        begin errors++; $display("[TB] FAIL ovf_sum got=%h exp=%h", sum_out, OVF_SUM); end
        checks++; if (select_out !== OVF_SUM[31]) begin errors++; $display("[TB] FAIL ovf_select got=%b exp=%b", select_out, OVF_SUM[31]); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    // HOLD with out_ready low for 3 cycles; start in HOLD is ignored,
    // including when it coincides with out_ready.
    task automatic test_backpressure();
        pulse_start();
        feed(t1_x, t12_w, 0, N_TERMS, 0);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            @(negedge clk);
            start = 1'b0;
            checks++; if (out_valid !== 1'b1)       begin errors++; $display("[TB] FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); end
            checks++; if (sum_out !== 32'h0001_6000) begin errors++; $display("[TB] FAIL bp_sum cyc=%0d got=%h exp=00016000", i, sum_out); end
            checks++; if (in_ready !== 1'b0)        begin errors++; $display("[TB] FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL bp_start_ignored got=%b exp=0", in_ready); end
    endtask

    // Restart mid-sum with a beat offered alongside start (must be dropped).
    task automatic test_restart();
        pulse_start();
        feed(t1_x, t12_w, 0, 2, 0);
        start    = 1'b1;
        in_valid = 1'b1;
        x_in     = 32'h7FFF_0000;
        w_in     = 32'h7FFF_0000;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL restart_in_ready got=%b exp=1", in_ready); end
        feed(t2_x, t12_w, 0, N_TERMS, 0);
        checks++; if (out_valid !== 1'b1)       begin errors++; $display("[TB] FAIL restart_valid got=%b exp=1", out_valid); end
        checks++; if (sum_out !== 32'hFFFF_C000) begin errors++; $display("[TB] FAIL restart_sum got=%h exp=ffffc000", sum_out); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    // Asynchronous reset part-way through a sum, then a clean sum.
    task automatic test_reset_mid();
        pulse_start();
        feed(t1_x, t12_w, 0, 2, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("[TB] FAIL rmid_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("[TB] FAIL rmid_valid got=%b exp=0", out_valid); end
        checks++; if (sum_out !== '0)      begin errors++; $display("[TB] FAIL rmid_sum got=%h exp=0", sum_out); end
        checks++; if (select_out !== 1'b0) begin errors++; $display("[TB] FAIL rmid_select got=%b exp=0", select_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("[TB] FAIL rmid_idle got=%b exp=0", in_ready); end
        pulse_start();
        feed(t1_x, t12_w, 0, N_TERMS, 0);
        checks++; if (sum_out !== 32'h0001_6000) begin errors++; $display("[TB] FAIL rmid_fresh_sum got=%h exp=00016000", sum_out); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    // in_valid in IDLE is ignored; gapped beats give the same result.
    task automatic test_gaps();
        in_valid = 1'b1;
        x_in     = 32'h0100_0000;
        w_in     = 32'h0100_0000;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_in_valid_ready got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        pulse_start();
        feed(t1_x, t12_w, 0, N_TERMS, 1);
        checks++; if (out_valid !== 1'b1)       begin errors++; $display("[TB] FAIL gaps_valid got=%b exp=1", out_valid); end
        checks++; if (sum_out !== 32'h0001_6000) begin errors++; $display("[TB] FAIL gaps_sum got=%h exp=00016000", sum_out); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    // Randomized sums against the reference model with random gaps/backpressure.
    task automatic test_random();
        word_t xs[N_TERMS];
        word_t ws[N_TERMS];
        word_t exp_sum;
        int    wait_cycles;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < N_TERMS; i++) begin
                if (t % 3 == 0) begin
                    xs[i] = $urandom;
                    ws[i] = $urandom;
                end else begin
                    xs[i] = $urandom & 32'h000F_FFFF;
                    ws[i] = $urandom & 32'h0003_FFFF;
                    if ($urandom_range(0, 1) == 1) xs[i] = -xs[i];
                    if ($urandom_range(0, 1) == 1) ws[i] = -ws[i];
                end
            end
            exp_sum = model_sum(xs, ws);
            pulse_start();
            feed(xs, ws, 0, N_TERMS, 2);
            checks++; if (out_valid !== 1'b1)          begin errors++; $display("[TB] FAIL rand_valid t=%0d got=%b exp=1", t, out_valid); end
            checks++; if (sum_out !== exp_sum)         begin errors++; $display("[TB] FAIL rand_sum t=%0d got=%h exp=%h", t, sum_out, exp_sum); end
            checks++; if (select_out !== exp_sum[31])  begin errors++; $display("[TB] FAIL rand_select t=%0d got=%b exp=%b", t, select_out, exp_sum[31]); end
            wait_cycles = $urandom_range(0, 3);
            repeat (wait_cycles) @(negedge clk);
            checks++; if (sum_out !== exp_sum)         begin errors++; $display("[TB] FAIL rand_stable t=%0d got=%h exp=%h", t, sum_out, exp_sum); end
            out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0)          begin errors++; $display("[TB] FAIL rand_release t=%0d got=%b exp=0", t, out_valid); end
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_restart();
        test_reset_mid();
        test_gaps();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
